range_session_arbiter: RTL and testbench



---
 rtl/range_session_arbiter_if.sv | 47 ++++
 rtl/range_session_arbiter.sv | 216 +++++++++++++++++++++
 tb/tb_range_session_arbiter.sv | 482 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/range_session_arbiter_if.sv
// range_session_arbiter_if
// Bundles every non-clock signal of the range session arbiter. The arbiter
// uses the slave modport. The surrounding environment (the sample sources,
// the range finder and the result consumer) uses the master modport.
//
// Signal summary (WIDTH = sample/range width):
//   req_valid[1:0]      per-requester beat valid
//   req_data[2*WIDTH]   requester i drives bits [i*WIDTH +: WIDTH]
//   req_last[1:0]       final beat of a session
//   req_ready[1:0]      beat accepted on valid & ready, at most one bit high
//   rf_data, rf_go, rf_finish   drive the shared range-finder datapath
//   rf_range, rf_error          returned by the datapath
//   res_valid/res_ready         held result handshake
//   res_id, res_range, res_error, res_timeout   result fields
interface range_session_arbiter_if #(
    parameter int WIDTH = 8
);
    logic [1:0]         req_valid;
    logic [2*WIDTH-1:0] req_data;
    logic [1:0]         req_last;
    logic [1:0]         req_ready;

    logic [WIDTH-1:0]   rf_data;
    logic               rf_go;
    logic               rf_finish;
    logic [WIDTH-1:0]   rf_range;
    logic               rf_error;

    logic               res_valid;
    logic               res_ready;
    logic               res_id;
    logic [WIDTH-1:0]   res_range;
    logic               res_error;
    logic               res_timeout;

    modport slave (
        input  req_valid, req_data, req_last, rf_range, rf_error, res_ready,
        output req_ready, rf_data, rf_go, rf_finish,
               res_valid, res_id, res_range, res_error, res_timeout
    );

    modport master (
        output req_valid, req_data, req_last, rf_range, rf_error, res_ready,
        input  req_ready, rf_data, rf_go, rf_finish,
               res_valid, res_id, res_range, res_error, res_timeout
    );
endinterface

// File: rtl/range_session_arbiter.sv
// range_session_arbiter
// Shares one range-finder datapath between two requesters. Each requester
// sends a framed session of samples. Sessions are granted round-robin at
// session boundaries. The block then sequences rf_go, the registered sample
// stream on rf_data, and rf_finish. The captured range is returned on a held
// valid/ready result port.
//
// Ports:
//   clock   clock
//   reset   asynchronous, active-high reset
//   bus     range_session_arbiter_if.slave (requester, datapath and result
//           signals)
//
// Parameters:
//   WIDTH    sample and range width
//   TIMEOUT  stall limit in cycles (1..255). Used only when the watchdog is
//            compiled in.
//
// Optional feature: define RANGE_SEQ_WATCHDOG_EN to add a stall watchdog.
// The watchdog closes a session once TIMEOUT consecutive STREAM cycles pass
// without a beat, and flags res_timeout. Without the macro, STREAM waits
// indefinitely and res_timeout is tied low.
module range_session_arbiter #(
    parameter int WIDTH   = 8,
    parameter int TIMEOUT = 16
) (
    input  logic                    clock,
    input  logic                    reset,
    range_session_arbiter_if.slave  bus
);

    typedef enum logic [2:0] {
        IDLE,
        FIRST,
        GO,
        STREAM,
        FINISH,
        RESULT
    } state_t;

    state_t             state_q, state_d;
    logic               grant_q, grant_d;
    logic               last_grant_q, last_grant_d;
    logic [WIDTH-1:0]   sample_q, sample_d;
    logic               last_q, last_d;
    logic               err_q, err_d;
    logic [WIDTH-1:0]   res_range_q, res_range_d;
    logic               res_id_q, res_id_d;
    logic [1:0]         ready;
    logic               accept;
    logic [WIDTH-1:0]   beat_data;
    logic               beat_last;

    // A TIMEOUT outside 1..255 cannot be represented by the 8-bit stall
    // counter, so such a value is rejected at elaboration.
    if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_timeout_range
        $error("range_session_arbiter: TIMEOUT must be within 1..255");
    end

`ifdef RANGE_SEQ_WATCHDOG_EN
    localparam logic [7:0] STALL_LIMIT = 8'(TIMEOUT - 1);

    logic [7:0]         stall_q, stall_d;
    logic               timeout_q, timeout_d;
`endif

    // Only the granted requester can ever see ready. Its beat is selected
    // here, and data from the other requester is ignored entirely.
    assign beat_data = grant_q ? bus.req_data[WIDTH +: WIDTH] : bus.req_data[0 +: WIDTH];
    assign beat_last = bus.req_last[grant_q];
    assign accept    = |(bus.req_valid & ready);

    // Ready is a pure function of state. In GO it is withheld after a
    // single-beat session, because the last beat has already been taken.
    always_comb begin
        ready = 2'b00;
        case (state_q)
            FIRST, STREAM: ready[grant_q] = 1'b1;
            GO:            ready[grant_q] = ~last_q;
            default:       ready = 2'b00;
        endcase
    end

    // Next-state logic. Arbitration happens only in IDLE, so a grant stays in
    // force until its result has been consumed. The error flag accumulates
    // over the active part of the session and is cleared only when the
    // result is handed over.
    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        sample_d     = sample_q;
        last_d       = last_q;
        err_d        = err_q;
        res_range_d  = res_range_q;
        res_id_d     = res_id_q;
`ifdef RANGE_SEQ_WATCHDOG_EN
        stall_d      = 8'd0;
        timeout_d    = timeout_q;
`endif
        case (state_q)
            IDLE: begin
                if (|bus.req_valid) begin
                    grant_d = (&bus.req_valid) ? ~last_grant_q : bus.req_valid[1];
                    state_d = FIRST;
                end
            end
            FIRST: begin
                if (accept) begin
                    sample_d = beat_data;
                    last_d   = beat_last;
                    state_d  = GO;
                end
            end
            GO: begin
                if (last_q) begin
                    state_d = FINISH;
                end else if (accept) begin
                    sample_d = beat_data;
                    state_d  = beat_last ? FINISH : STREAM;
                end else begin
                    state_d = STREAM;
                end
            end
            STREAM: begin
                if (accept) begin
                    sample_d = beat_data;
                    if (beat_last) begin
                        state_d = FINISH;
                    end
                end else begin
`ifdef RANGE_SEQ_WATCHDOG_EN
                    if (stall_q == STALL_LIMIT) begin
                        timeout_d = 1'b1;
                        state_d   = FINISH;
                    end else begin
                        stall_d = stall_q + 8'd1;
                    end
`endif
                end
            end
            FINISH: begin
                res_range_d = bus.rf_range;
                res_id_d    = grant_q;
                state_d     = RESULT;
            end
            RESULT: begin
                if (bus.res_ready) begin
                    last_grant_d = grant_q;
                    err_d        = 1'b0;
`ifdef RANGE_SEQ_WATCHDOG_EN
                    timeout_d    = 1'b0;
`endif
                    state_d      = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (bus.rf_error && (state_q inside {FIRST, GO, STREAM, FINISH})) begin
            err_d = 1'b1;
        end
    end

    // State and datapath registers. last_grant resets to 1 so that
    // requester 0 wins the first contested arbitration.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            grant_q      <= 1'b0;
            last_grant_q <= 1'b1;
            sample_q     <= '0;
            last_q       <= 1'b0;
            err_q        <= 1'b0;
            res_range_q  <= '0;
            res_id_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            sample_q     <= sample_d;
            last_q       <= last_d;
            err_q        <= err_d;
            res_range_q  <= res_range_d;
            res_id_q     <= res_id_d;
        end
    end

`ifdef RANGE_SEQ_WATCHDOG_EN
    // The stall counter restarts on every accepted beat and whenever STREAM
    // is left. The timeout flag lives until the result is consumed.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            stall_q   <= 8'd0;
            timeout_q <= 1'b0;
        end else begin
            stall_q   <= stall_d;
            timeout_q <= timeout_d;
        end
    end

    assign bus.res_timeout = timeout_q;
`else
    assign bus.res_timeout = 1'b0;
`endif

    assign bus.req_ready = ready;
    assign bus.rf_data   = sample_q;
    assign bus.rf_go     = (state_q == GO);
    assign bus.rf_finish = (state_q == FINISH);
    assign bus.res_valid = (state_q == RESULT);
    assign bus.res_id    = res_id_q;
    assign bus.res_range = res_range_q;
    assign bus.res_error = err_q;

endmodule

// File: tb/tb_range_session_arbiter.sv
// tb_range_session_arbiter
// Directed bench for range_session_arbiter. A small behavioural range finder
// (min/max tracker) stands in for the shared datapath. Each scenario task
// drives its own stimulus and compares against hand-computed values.
// Build with RANGE_SEQ_WATCHDOG_EN defined to exercise the watchdog
// scenario in place of the plain stall scenario.
module tb_range_session_arbiter;

    localparam int W = 8;

    typedef logic [W-1:0] beat_arr_t [4];

    logic           clock;
    logic           reset;
    logic           rf_err_drive;
    int             errors;
    int             checks;
    int             go_cnt;
    int             fin_cnt;
    bit             both_seen;
    logic [W-1:0]   dp_min, dp_max, dp_lo, dp_hi;

    range_session_arbiter_if #(.WIDTH(W)) bus ();

    range_session_arbiter #(
        .WIDTH   (W),
        .TIMEOUT (4)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Behavioural range finder: rf_go loads min/max, and every later cycle
    // folds rf_data in. The range is valid combinationally during
    // rf_finish and includes the sample presented in that cycle.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            dp_min <= '0;
            dp_max <= '0;
        end else if (bus.rf_go) begin
            dp_min <= bus.rf_data;
            dp_max <= bus.rf_data;
        end else begin
            dp_min <= (bus.rf_data < dp_min) ? bus.rf_data : dp_min;
            dp_max <= (bus.rf_data > dp_max) ? bus.rf_data : dp_max;
        end
    end

    always_comb begin
        dp_lo = (bus.rf_data < dp_min) ? bus.rf_data : dp_min;
        dp_hi = (bus.rf_data > dp_max) ? bus.rf_data : dp_max;
        bus.rf_range = bus.rf_finish ? (dp_hi - dp_lo) : '0;
    end

    assign bus.rf_error = rf_err_drive;

    // Counts datapath strobes and watches for both ready bits high together.
    always @(negedge clock) begin
        if (bus.rf_go)              go_cnt    <= go_cnt + 1;
        if (bus.rf_finish)          fin_cnt   <= fin_cnt + 1;
        if (bus.req_ready == 2'b11) both_seen <= 1'b1;
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic release_result();
        bus.res_ready = 1'b1;
        tick();
        bus.res_ready = 1'b0;
    endtask

    // Presents n beats from requester id, waiting (bounded) for ready on
    // each beat. Returns at the cycle after the last beat was accepted.
    task automatic send_beats(input int id, input int n, input beat_arr_t b, output bit ok);
        int guard;
        ok = 1'b1;
        for (int i = 0; i < n; i++) begin
            bus.req_valid[id]        = 1'b1;
            bus.req_data[id*W +: W]  = b[i];
            bus.req_last[id]         = (i == n - 1);
            guard = 0;
            while (bus.req_ready[id] !== 1'b1 && guard < 50) begin
                tick();
                guard++;
            end
            if (guard >= 50) ok = 1'b0;
            tick();
        end
        bus.req_valid[id] = 1'b0;
        bus.req_last[id]  = 1'b0;
    endtask

    task automatic wait_result(output bit ok);
        int guard;
        guard = 0;
        while (bus.res_valid !== 1'b1 && guard < 50) begin
            tick();
            guard++;
        end
        ok = (bus.res_valid === 1'b1);
    endtask

    task automatic test_reset();
        reset         = 1'b1;
        bus.req_valid = 2'b00;
        bus.req_data  = '0;
        bus.req_last  = 2'b00;
        bus.res_ready = 1'b0;
        rf_err_drive  = 1'b0;
        tick();
        tick();
        checks++;
        if ({bus.req_ready, bus.rf_go, bus.rf_finish, bus.rf_data} !== 12'h000) begin
            errors++;
            $display("[TB] FAIL reset_rf: ready=%b go=%b finish=%b data=%0h expected all 0",
                     bus.req_ready, bus.rf_go, bus.rf_finish, bus.rf_data);
        end
        checks++;
        if ({bus.res_valid, bus.res_id, bus.res_range, bus.res_error, bus.res_timeout} !== 12'h000) begin
            errors++;
            $display("[TB] FAIL reset_res: valid=%b id=%b range=%0h err=%b to=%b expected all 0",
                     bus.res_valid, bus.res_id, bus.res_range, bus.res_error, bus.res_timeout);
        end
        reset = 1'b0;
        tick();
        tick();
        checks++;
        if (bus.req_ready !== 2'b00 || bus.res_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL idle_after_reset: ready=%b res_valid=%b expected 00/0",
                     bus.req_ready, bus.res_valid);
        end
    endtask

    task automatic test_multi_beat();
        beat_arr_t beats = '{8'd5, 8'd9, 8'd2, 8'd7};
        int go0, fin0;
        go0  = go_cnt;
        fin0 = fin_cnt;
        bus.req_valid    = 2'b01;
        bus.req_data     = '0;
        bus.req_data[W-1:0] = beats[0];
        bus.req_last     = 2'b00;
        tick();
        checks++;
        if (bus.req_ready !== 2'b01) begin
            errors++;
            $display("[TB] FAIL grant_latency: req_ready=%b expected 01", bus.req_ready);
        end
        for (int i = 0; i < 4; i++) begin
            bus.req_data[W-1:0] = beats[i];
            bus.req_last        = (i == 3) ? 2'b01 : 2'b00;
            tick();
            if (i == 0) begin
                checks++;
                if (bus.rf_go !== 1'b1 || bus.rf_data !== 8'd5) begin
                    errors++;
                    $display("[TB] FAIL go_first_beat: go=%b data=%0d expected 1/5", bus.rf_go, bus.rf_data);
                end
            end
        end
        bus.req_valid = 2'b00;
        bus.req_last  = 2'b00;
        checks++;
        if (bus.rf_finish !== 1'b1 || bus.res_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL finish_timing: finish=%b res_valid=%b expected 1/0", bus.rf_finish, bus.res_valid);
        end
        tick();
        checks++;
        if ({bus.res_valid, bus.res_id, bus.res_range, bus.res_error} !== {1'b1, 1'b0, 8'd7, 1'b0}) begin
            errors++;
            $display("[TB] FAIL multi_result: valid=%b id=%b range=%0d err=%b expected 1/0/7/0",
                     bus.res_valid, bus.res_id, bus.res_range, bus.res_error);
        end
        checks++;
        if (go_cnt - go0 !== 1 || fin_cnt - fin0 !== 1) begin
            errors++;
            $display("[TB] FAIL strobe_count: go=%0d finish=%0d expected 1/1", go_cnt - go0, fin_cnt - fin0);
        end
        release_result();
        checks++;
        if (bus.res_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL result_release: res_valid=%b expected 0", bus.res_valid);
        end
    endtask

    task automatic test_error();
        bus.req_valid       = 2'b01;
        bus.req_data[W-1:0] = 8'd1;
        bus.req_last        = 2'b00;
        tick();
        tick();
        rf_err_drive        = 1'b1;
        bus.req_data[W-1:0] = 8'd3;
        bus.req_last        = 2'b01;
        tick();
        rf_err_drive  = 1'b0;
        bus.req_valid = 2'b00;
        bus.req_last  = 2'b00;
        tick();
        checks++;
        if ({bus.res_valid, bus.res_range, bus.res_error} !== {1'b1, 8'd2, 1'b1}) begin
            errors++;
            $display("[TB] FAIL error_flag: valid=%b range=%0d err=%b expected 1/2/1",
                     bus.res_valid, bus.res_range, bus.res_error);
        end
        release_result();
    endtask

    task automatic test_single_beat();
        bus.req_valid        = 2'b10;
        bus.req_data[2*W-1:W] = 8'h42;
        bus.req_last         = 2'b10;
        tick();
        checks++;
        if (bus.req_ready !== 2'b10) begin
            errors++;
            $display("[TB] FAIL single_grant: req_ready=%b expected 10", bus.req_ready);
        end
        tick();
        bus.req_valid = 2'b00;
        bus.req_last  = 2'b00;
        checks++;
        if (bus.rf_go !== 1'b1 || bus.rf_finish !== 1'b0 || bus.req_ready !== 2'b00) begin
            errors++;
            $display("[TB] FAIL single_go: go=%b finish=%b ready=%b expected 1/0/00",
                     bus.rf_go, bus.rf_finish, bus.req_ready);
        end
        tick();
        checks++;
        if (bus.rf_go !== 1'b0 || bus.rf_finish !== 1'b1) begin
            errors++;
            $display("[TB] FAIL single_finish: go=%b finish=%b expected 0/1", bus.rf_go, bus.rf_finish);
        end
        tick();
        checks++;
        if ({bus.res_valid, bus.res_id, bus.res_range, bus.res_error} !== {1'b1, 1'b1, 8'd0, 1'b0}) begin
            errors++;
            $display("[TB] FAIL single_result: valid=%b id=%b range=%0d err=%b expected 1/1/0/0",
                     bus.res_valid, bus.res_id, bus.res_range, bus.res_error);
        end
        release_result();
        checks++;
        if (bus.res_valid !== 1'b0 || bus.req_ready !== 2'b00) begin
            errors++;
            $display("[TB] FAIL turnaround: res_valid=%b ready=%b expected 0/00", bus.res_valid, bus.req_ready);
        end
    endtask

`ifdef RANGE_SEQ_WATCHDOG_EN
    task automatic test_watchdog();
        int cnt;
        bus.req_valid       = 2'b01;
        bus.req_data[W-1:0] = 8'd3;
        bus.req_last        = 2'b00;
        tick();
        tick();
        bus.req_data[W-1:0] = 8'd10;
        tick();
        bus.req_valid = 2'b00;
        cnt = 0;
        while (bus.rf_finish !== 1'b1 && cnt < 20) begin
            tick();
            cnt++;
        end
        checks++;
        if (cnt !== 4) begin
            errors++;
            $display("[TB] FAIL watchdog_delay: stall cycles=%0d expected 4", cnt);
        end
        bus.req_valid       = 2'b01;
        bus.req_data[W-1:0] = 8'd99;
        tick();
        checks++;
        if ({bus.res_valid, bus.res_range, bus.res_timeout, bus.req_ready} !== {1'b1, 8'd7, 1'b1, 2'b00}) begin
            errors++;
            $display("[TB] FAIL watchdog_result: valid=%b range=%0d to=%b ready=%b expected 1/7/1/00",
                     bus.res_valid, bus.res_range, bus.res_timeout, bus.req_ready);
        end
        bus.req_valid = 2'b00;
        release_result();
        checks++;
        if (bus.res_timeout !== 1'b0) begin
            errors++;
            $display("[TB] FAIL timeout_clear: res_timeout=%b expected 0", bus.res_timeout);
        end
    endtask
`else
    task automatic test_stall();
        bit held_bad;
        bus.req_valid       = 2'b01;
        bus.req_data[W-1:0] = 8'd10;
        bus.req_last        = 2'b00;
        tick();
        tick();
        bus.req_valid = 2'b00;
        tick();
        held_bad = 1'b0;
        for (int k = 0; k < 6; k++) begin
            tick();
            if (bus.rf_data !== 8'd10 || bus.req_ready !== 2'b01) held_bad = 1'b1;
        end
        checks++;
        if (held_bad) begin
            errors++;
            $display("[TB] FAIL stall_hold: data=%0d ready=%b expected 10/01", bus.rf_data, bus.req_ready);
        end
        bus.req_valid       = 2'b01;
        bus.req_data[W-1:0] = 8'd20;
        bus.req_last        = 2'b01;
        tick();
        bus.req_valid = 2'b00;
        bus.req_last  = 2'b00;
        tick();
        checks++;
        if ({bus.res_valid, bus.res_range, bus.res_timeout} !== {1'b1, 8'd10, 1'b0}) begin
            errors++;
            $display("[TB] FAIL stall_result: valid=%b range=%0d to=%b expected 1/10/0",
                     bus.res_valid, bus.res_range, bus.res_timeout);
        end
        release_result();
    endtask
`endif

    task automatic test_hold_result();
        beat_arr_t b = '{8'd4, 8'd12, 8'd0, 8'd0};
        bit ok;
        send_beats(0, 2, b, ok);
        wait_result(ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("[TB] FAIL hold_wait: res_valid=%b expected 1", bus.res_valid);
        end
        bus.req_valid = 2'b11;
        for (int k = 0; k < 10; k++) begin
            checks++;
            if ({bus.res_valid, bus.res_id, bus.res_range, bus.res_error, bus.res_timeout,
                 bus.req_ready, bus.rf_go, bus.rf_finish} !==
                {1'b1, 1'b0, 8'd8, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0}) begin
                errors++;
                $display("[TB] FAIL hold_stable: valid=%b id=%b range=%0d ready=%b go=%b fin=%b expected 1/0/8/00/0/0",
                         bus.res_valid, bus.res_id, bus.res_range, bus.req_ready, bus.rf_go, bus.rf_finish);
            end
            tick();
        end
        bus.req_valid = 2'b00;
        release_result();
    endtask

    task automatic test_reset_mid();
        beat_arr_t b0 = '{8'd9, 8'd0, 8'd0, 8'd0};
        beat_arr_t b1 = '{8'd4, 8'd1, 8'd0, 8'd0};
        bit ok;
        bus.req_valid       = 2'b01;
        bus.req_data[W-1:0] = 8'd1;
        bus.req_last        = 2'b00;
        tick();
        tick();
        bus.req_data[W-1:0] = 8'd2;
        tick();
        checks++;
        if (bus.rf_data !== 8'd2 || bus.req_ready !== 2'b01) begin
            errors++;
            $display("[TB] FAIL mid_stream: data=%0d ready=%b expected 2/01", bus.rf_data, bus.req_ready);
        end
        reset = 1'b1;
        #1;
        checks++;
        if ({bus.req_ready, bus.rf_go, bus.rf_finish, bus.rf_data, bus.res_valid, bus.res_id,
             bus.res_range, bus.res_error, bus.res_timeout} !== 24'h0) begin
            errors++;
            $display("[TB] FAIL async_reset: ready=%b data=%0d res_valid=%b range=%0d expected all 0",
                     bus.req_ready, bus.rf_data, bus.res_valid, bus.res_range);
        end
        bus.req_valid = 2'b00;
        bus.req_data  = '0;
        tick();
        reset = 1'b0;
        tick();
        bus.req_valid[1]      = 1'b1;
        bus.req_data[2*W-1:W] = 8'd4;
        bus.req_last[1]       = 1'b0;
        send_beats(0, 1, b0, ok);
        wait_result(ok);
        checks++;
        if (!ok || bus.res_id !== 1'b0 || bus.res_range !== 8'd0) begin
            errors++;
            $display("[TB] FAIL post_reset_grant: ok=%b id=%b range=%0d expected 1/0/0", ok, bus.res_id, bus.res_range);
        end
        release_result();
        send_beats(1, 2, b1, ok);
        wait_result(ok);
        checks++;
        if (!ok || bus.res_id !== 1'b1 || bus.res_range !== 8'd3) begin
            errors++;
            $display("[TB] FAIL post_reset_req1: ok=%b id=%b range=%0d expected 1/1/3", ok, bus.res_id, bus.res_range);
        end
        release_result();
    endtask

    task automatic test_round_robin();
        int k;
        int guard;
        int go0;
        reset = 1'b1;
        bus.req_valid = 2'b00;
        bus.req_last  = 2'b00;
        tick();
        reset = 1'b0;
        tick();
        go0 = go_cnt;
        bus.req_valid = 2'b11;
        bus.req_data  = {8'h22, 8'h11};
        bus.req_last  = 2'b11;
        bus.res_ready = 1'b1;
        k = 0;
        guard = 0;
        while (k < 6 && guard < 100) begin
            tick();
            guard++;
            if (bus.res_valid === 1'b1) begin
                checks++;
                if (bus.res_id !== k[0] || bus.res_range !== 8'd0) begin
                    errors++;
                    $display("[TB] FAIL rr_order: session %0d id=%b range=%0d expected %b/0",
                             k, bus.res_id, bus.res_range, k[0]);
                end
                k++;
            end
        end
        bus.req_valid = 2'b00;
        bus.req_last  = 2'b00;
        tick();
        bus.res_ready = 1'b0;
        checks++;
        if (k !== 6 || go_cnt - go0 !== 6) begin
            errors++;
            $display("[TB] FAIL rr_count: results=%0d go=%0d expected 6/6", k, go_cnt - go0);
        end
        checks++;
        if (both_seen !== 1'b0) begin
            errors++;
            $display("[TB] FAIL ready_onehot: both ready seen=%b expected 0", both_seen);
        end
    endtask

    initial begin
        test_reset();
        test_multi_beat();
        test_error();
        test_single_beat();
`ifdef RANGE_SEQ_WATCHDOG_EN
        test_watchdog();
`else
        test_stall();
`endif
        test_hold_result();
        test_reset_mid();
        test_round_robin();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL global_timeout: simulation time limit reached before completion");
        $fatal(1, "[TB] aborted");
    end

endmodule
